// File: rtl/flex_counter_ud_if.sv
// Control/status bundle for flex_counter_ud: master drives controls, slave returns count and flags.
// Latency: pure wiring, no storage.
// Backpressure: none; count_enable is an advance request that is never refused.
// Optional macro FLEX_PRESCALE_EN adds the prescale_val field.
interface flex_counter_ud_if #(
    parameter int NUM_CNT_BITS = 4
`ifdef FLEX_PRESCALE_EN
    ,
    parameter int PRESCALE_BITS = 4
`endif
);
    logic                    clear;
    logic                    load;
    logic [NUM_CNT_BITS-1:0] load_val;
    logic                    count_enable;
    logic                    count_up;
    logic [1:0]              mode;
    logic [NUM_CNT_BITS-1:0] rollover_val;
`ifdef FLEX_PRESCALE_EN
    logic [PRESCALE_BITS-1:0] prescale_val;
`endif
    logic [NUM_CNT_BITS-1:0] count_out;
    logic                    rollover_flag;
    logic                    wrap_pulse;
    logic                    done;

    modport master (
        output clear, load, load_val, count_enable, count_up, mode, rollover_val,
`ifdef FLEX_PRESCALE_EN
        output prescale_val,
`endif
        input  count_out, rollover_flag, wrap_pulse, done
    );

    modport slave (
        input  clear, load, load_val, count_enable, count_up, mode, rollover_val,
`ifdef FLEX_PRESCALE_EN
        input  prescale_val,
`endif
        output count_out, rollover_flag, wrap_pulse, done
    );
endinterface

// File: rtl/flex_counter_ud.sv
// Up/down flexible counter with programmable terminal, parallel load and wrap/saturate/one-shot modes.
// Latency: 1 cycle from an enabled edge to new count_out and flags; all outputs registered.
// Backpressure: none; one-shot done blocks advance until clear or load.
// Optional macro FLEX_PRESCALE_EN adds a clock-enable prescaler dividing by prescale_val+1.
module flex_counter_ud #(
    parameter int NUM_CNT_BITS = 4
`ifdef FLEX_PRESCALE_EN
    ,
    parameter int PRESCALE_BITS = 4
`endif
) (
    input  logic                clk,
    input  logic                rst,
    flex_counter_ud_if.slave    bus
);
    localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

    logic [NUM_CNT_BITS-1:0] cnt_q, cnt_d;
    logic                    flag_q, flag_d;
    logic                    wrap_q, wrap_d;
    logic                    done_q, done_d;
    logic [NUM_CNT_BITS-1:0] term_val;
    logic                    tick;
    logic                    advance;
    logic                    wrap_mode;
    logic                    one_shot;
    logic                    rv_zero;

    // Modes 00 and 11 both wrap; 01 saturates; 10 is one-shot.
    assign wrap_mode = (bus.mode == 2'b00) || (bus.mode == 2'b11);
    assign one_shot  = (bus.mode == 2'b10);
    assign rv_zero   = (bus.rollover_val == '0);
    // Down counting terminates at 1 and reloads from rollover_val.
    assign term_val  = bus.count_up ? bus.rollover_val : ONE;

`ifdef FLEX_PRESCALE_EN
    logic [PRESCALE_BITS-1:0] pre_q, pre_d;

    assign tick = (pre_q == bus.prescale_val);

    // Prescaler only moves on enabled cycles and restarts on every tick, clear or load.
    always_comb begin
        pre_d = pre_q;
        if (bus.clear || bus.load) begin
            pre_d = '0;
        end else if (bus.count_enable) begin
            pre_d = tick ? '0 : pre_q + PRESCALE_BITS'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // A zero terminal freezes the counter entirely.
    assign advance = bus.count_enable && !done_q && tick && !rv_zero;

    // Next count, wrap pulse, sticky done and terminal flag from the clear > load > advance > hold priority.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        done_d = done_q;
        if (bus.clear) begin
            cnt_d  = '0;
            done_d = 1'b0;
        end else if (bus.load) begin
            cnt_d  = bus.load_val;
            done_d = 1'b0;
        end else if (advance) begin
            if (bus.count_up) begin
                if (cnt_q >= bus.rollover_val) begin
                    if (wrap_mode) begin
                        cnt_d  = ONE;
                        wrap_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end else begin
                if (cnt_q <= ONE) begin
                    if (wrap_mode) begin
                        cnt_d  = bus.rollover_val;
                        wrap_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            if (one_shot && (cnt_d == term_val)) begin
                done_d = 1'b1;
            end
        end
        // Flag tracks the next count every cycle, so terminal or direction changes show up on hold too.
        flag_d = (cnt_d == term_val) && !rv_zero;
    end

    // Count and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            flag_q <= 1'b0;
            wrap_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
            wrap_q <= wrap_d;
            done_q <= done_d;
        end
    end

    assign bus.count_out     = cnt_q;
    assign bus.rollover_flag = flag_q;
    assign bus.wrap_pulse    = wrap_q;
    assign bus.done          = done_q;
endmodule

// File: tb/tb_flex_counter_ud.sv
// Directed bench for flex_counter_ud: a spec-level model checked every cycle plus literal checkpoints.
module tb_flex_counter_ud;
    logic clk;
    logic rst;

    int n_tests = 0;
    int n_fail  = 0;

    flex_counter_ud_if #(.NUM_CNT_BITS(4)) bus ();
    flex_counter_ud #(.NUM_CNT_BITS(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: plain integers following the counting rules.
    int m_cnt  = 0;
    int m_pre  = 0;
    bit m_flag = 0;
    bit m_wrap = 0;
    bit m_done = 0;

    always @(posedge clk or posedge rst) begin : model
        int t;
        int nxt;
        int rv;
        bit wr;
        bit tk;
        if (rst) begin
            m_cnt = 0; m_pre = 0; m_flag = 0; m_wrap = 0; m_done = 0;
        end else begin
            rv  = int'(bus.rollover_val);
            t   = bus.count_up ? rv : 1;
            nxt = m_cnt;
            wr  = 0;
`ifdef FLEX_PRESCALE_EN
            tk = (m_pre == int'(bus.prescale_val));
`else
            tk = 1;
`endif
            if (bus.clear) begin
                nxt = 0; m_done = 0; m_pre = 0;
            end else if (bus.load) begin
                nxt = int'(bus.load_val); m_done = 0; m_pre = 0;
            end else begin
                if (bus.count_enable && !m_done && tk && rv != 0) begin
                    if (bus.count_up) begin
                        if (m_cnt < rv) nxt = m_cnt + 1;
                        else if (bus.mode == 2'd0 || bus.mode == 2'd3) begin nxt = 1; wr = 1; end
                    end else begin
                        if (m_cnt > 1) nxt = m_cnt - 1;
                        else if (bus.mode == 2'd0 || bus.mode == 2'd3) begin nxt = rv; wr = 1; end
                    end
                    if (bus.mode == 2'd2 && nxt == t) m_done = 1;
                end
                if (bus.count_enable) m_pre = tk ? 0 : (m_pre + 1) % 16;
            end
            m_flag = (nxt == t) && (rv != 0);
            m_wrap = wr;
            m_cnt  = nxt;
        end
    end

    // Per-cycle compare of DUT against the model, 1 time unit after the edge.
    always @(posedge clk) begin
        #1;
        n_tests++;
        if (bus.count_out !== 4'(m_cnt) || bus.rollover_flag !== m_flag ||
            bus.wrap_pulse !== m_wrap || bus.done !== m_done) begin
            n_fail++;
            $display("FAIL model_cycle t=%0t: got cnt=%0d flag=%b wrap=%b done=%b, expected cnt=%0d flag=%b wrap=%b done=%b",
                     $time, bus.count_out, bus.rollover_flag, bus.wrap_pulse, bus.done,
                     m_cnt, m_flag, m_wrap, m_done);
        end
    end

    task automatic chk(input string nm, input int c, input bit f, input bit w, input bit d);
        n_tests++;
        if (bus.count_out !== 4'(c) || bus.rollover_flag !== f || bus.wrap_pulse !== w || bus.done !== d) begin
            n_fail++;
            $display("FAIL %s: got cnt=%0d flag=%b wrap=%b done=%b, expected cnt=%0d flag=%b wrap=%b done=%b",
                     nm, bus.count_out, bus.rollover_flag, bus.wrap_pulse, bus.done, c, f, w, d);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    int up_c [7] = '{1, 2, 3, 4, 5, 1, 2};
    bit up_f [7] = '{0, 0, 0, 0, 1, 0, 0};
    bit up_w [7] = '{0, 0, 0, 0, 0, 1, 0};
    int dw_c [3] = '{1, 5, 4};
    bit dw_f [3] = '{1, 0, 0};
    bit dw_w [3] = '{0, 1, 0};
    int sat_c [4] = '{2, 1, 1, 1};
    bit sat_f [4] = '{0, 1, 1, 1};
    int os_c [5] = '{1, 2, 3, 3, 3};
    bit os_f [5] = '{0, 0, 1, 1, 1};
    bit os_d [5] = '{0, 0, 1, 1, 1};
`ifdef FLEX_PRESCALE_EN
    int ps_c [5] = '{0, 0, 1, 1, 1};
`endif

    initial begin
        bus.clear = 0; bus.load = 0; bus.load_val = '0; bus.count_enable = 0;
        bus.count_up = 1; bus.mode = 2'd0; bus.rollover_val = '0;
`ifdef FLEX_PRESCALE_EN
        bus.prescale_val = '0;
`endif
        rst = 0;
        #1 rst = 1;
        #2;
        chk("reset_values", 0, 0, 0, 0);
        step();
        rst = 0;

        // Count to 7, then async reset mid-count.
        bus.rollover_val = 4'd9; bus.count_enable = 1;
        repeat (7) step();
        chk("pre_reset_count", 7, 0, 0, 0);
        rst = 1;
        #1;
        chk("async_reset_mid", 0, 0, 0, 0);
        step();
        rst = 0; bus.count_enable = 0;
        step(); step();
        chk("hold_after_reset", 0, 0, 0, 0);

        // Up wrap at rollover 5.
        bus.rollover_val = 4'd5; bus.mode = 2'd0; bus.count_enable = 1;
        for (int i = 0; i < 7; i++) begin
            step();
            chk($sformatf("up_wrap[%0d]", i), up_c[i], up_f[i], up_w[i], 0);
        end

        // Down wrap: 2 -> 1 -> reload 5 with pulse -> 4.
        bus.count_enable = 0; bus.count_up = 0; bus.load_val = 4'd2; bus.load = 1;
        step();
        chk("load_2", 2, 0, 0, 0);
        bus.load = 0; bus.count_enable = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("down_wrap[%0d]", i), dw_c[i], dw_f[i], dw_w[i], 0);
        end

        // Down saturate from 3.
        bus.count_enable = 0; bus.load_val = 4'd3; bus.load = 1;
        step();
        chk("load_3", 3, 0, 0, 0);
        bus.load = 0; bus.mode = 2'd1; bus.count_enable = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("down_sat[%0d]", i), sat_c[i], sat_f[i], 0, 0);
        end

        // One-shot up to 3, then load 0 restarts.
        bus.count_enable = 0; bus.clear = 1;
        step();
        chk("clear", 0, 0, 0, 0);
        bus.clear = 0; bus.count_up = 1; bus.rollover_val = 4'd3; bus.mode = 2'd2; bus.count_enable = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("one_shot[%0d]", i), os_c[i], os_f[i], 0, os_d[i]);
        end
        bus.load_val = 4'd0; bus.load = 1;
        step();
        chk("oneshot_load0", 0, 0, 0, 0);
        bus.load = 0;
        step();
        chk("oneshot_resume", 1, 0, 0, 0);

        // Priority: clear over load over advance; load over advance.
        bus.load_val = 4'd6; bus.load = 1;
        step();
        chk("load_6", 6, 0, 0, 0);
        bus.clear = 1; bus.load = 1; bus.load_val = 4'd9;
        step();
        chk("prio_clear", 0, 0, 0, 0);
        bus.clear = 0;
        step();
        chk("prio_load_9", 9, 0, 0, 0);
        bus.load = 0;
        step();
        chk("oneshot_above_term_hold", 9, 0, 0, 0);
        bus.mode = 2'd3;
        step();
        chk("mode11_wrap_above_term", 1, 0, 1, 0);

        // rollover_val = 0 freezes the count with flag low.
        bus.rollover_val = 4'd0;
        repeat (3) step();
        chk("rv0_frozen", 1, 0, 0, 0);
        // Terminal change updates flag on a hold cycle.
        bus.count_enable = 0; bus.rollover_val = 4'd1;
        step();
        chk("flag_on_hold", 1, 1, 0, 0);

`ifdef FLEX_PRESCALE_EN
        bus.clear = 1;
        step();
        bus.clear = 0; bus.rollover_val = 4'd2; bus.mode = 2'd0; bus.prescale_val = 4'd2; bus.count_enable = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("prescale[%0d]", i), ps_c[i], 0, 0, 0);
        end
        bus.count_enable = 0;
        step(); step();
        chk("prescale_gap", 1, 0, 0, 0);
        bus.count_enable = 1;
        step();
        chk("prescale_after_gap", 2, 1, 0, 0);
        bus.rollover_val = 4'd0;
        repeat (3) step();
        chk("prescale_rv0", 2, 0, 0, 0);
`endif

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
